// File: rtl/scope_pkg.sv
// Shared definitions for the scope acquisition blocks.
package scope_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } cap_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit scope inputs.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/capture_controller.sv
// Acquisition sequencer: fills the pre-trigger window, arms the trigger
// manager, then captures post-trigger samples into a circular RAM.
module capture_controller
  import scope_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Ack,
  input  logic              ForceTrig,
  input  logic [ADDR_W-1:0] PreCount,
  input  logic [ADDR_W:0]   PostCount,
  input  logic              SampleEn,
  input  logic              Trig,
  output logic              TrigReset,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [ADDR_W-1:0] TrigAddr,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W:0]   post_q, post_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              trig_reset_q, trig_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              trig_sync;
  logic              wr_en;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   pre_ext;
  logic [ADDR_W:0]   post_limit;
  logic [ADDR_W:0]   post_sat;

  sync2 u_trig_sync (
    .clk  (Clk),
    .rst_n(Reset_n),
    .d    (Trig),
    .q    (trig_sync)
  );

  // Post-trigger length may not overrun the pre-trigger samples in the ring.
  assign post_limit = DEPTH - {1'b0, PreCount};
  assign post_sat   = (PostCount > post_limit) ? post_limit : PostCount;
  assign pre_ext    = {1'b0, pre_q};
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    pre_d       = pre_q;
    post_d      = post_q;
    cnt_d       = cnt_q;

    // Writes stop once a window is full, so zero-length windows write nothing.
    unique case (state_q)
      S_ARM:       wr_en = SampleEn && (cnt_q != pre_ext);
      S_WAIT_TRIG: wr_en = SampleEn;
      S_POST:      wr_en = SampleEn && (cnt_q != post_q);
      default:     wr_en = 1'b0;
    endcase

    if (wr_en) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    if (Abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            pre_d   = PreCount;
            post_d  = post_sat;
            cnt_d   = '0;
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          if (cnt_q == pre_ext) begin
            state_d = S_WAIT_TRIG;
          end else if (wr_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_ext) begin
              state_d = S_WAIT_TRIG;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (trig_sync || ForceTrig) begin
            trig_addr_d = wr_addr_d;
            cnt_d       = '0;
            state_d     = S_POST;
          end
        end
        S_POST: begin
          if (cnt_q == post_q) begin
            state_d = S_DONE;
          end else if (wr_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_q) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (Ack) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    trig_reset_d = (state_d != S_WAIT_TRIG);
    busy_d       = (state_d == S_ARM) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      cnt_q        <= '0;
      trig_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      trig_addr_q  <= trig_addr_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      cnt_q        <= cnt_d;
      trig_reset_q <= trig_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign WrEn      = wr_en;
  assign WrAddr    = wr_addr_q;
  assign TrigAddr  = trig_addr_q;
  assign TrigReset = trig_reset_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench for capture_controller with a transaction-level reference model.
module tb_capture_controller;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_WAIT = 2;
  localparam int P_POST = 3;
  localparam int P_DONE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, ack = 1'b0, force_trig = 1'b0;
  logic          sample_en = 1'b0, trig = 1'b0;
  logic [AW-1:0] pre_count = '0;
  logic [AW:0]   post_count = '0;
  logic          trig_reset, wr_en, busy, done;
  logic [AW-1:0] wr_addr, trig_addr;

  always #5 clk = ~clk;

  capture_controller #(.ADDR_W(AW)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Start    (start),
    .Abort    (abort),
    .Ack      (ack),
    .ForceTrig(force_trig),
    .PreCount (pre_count),
    .PostCount(post_count),
    .SampleEn (sample_en),
    .Trig     (trig),
    .TrigReset(trig_reset),
    .WrEn     (wr_en),
    .WrAddr   (wr_addr),
    .TrigAddr (trig_addr),
    .Busy     (busy),
    .Done     (done)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          trst;
    logic          wr;
    logic [AW-1:0] taddr;
  } exp_t;

  exp_t          stq[$];
  logic [AW-1:0] wq[$];

  int n_checks = 0;
  int n_pass = 0;
  int dut_writes = 0;

  // Reference model: phase plus "samples still owed" for each window.
  int          ph = P_IDLE;
  int unsigned m_addr = 0, m_taddr = 0, pre_left = 0, post_left = 0;
  bit          s1 = 1'b0, s2 = 1'b0;
  bit          arm_only = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic model_eval();
    exp_t e;
    bit   wr, hit;
    int unsigned room;
    if (!rst_n) begin
      ph = P_IDLE; m_addr = 0; m_taddr = 0; pre_left = 0; post_left = 0;
      s1 = 1'b0; s2 = 1'b0;
    end
    wr = sample_en && ((ph == P_ARM && pre_left > 0) || ph == P_WAIT ||
                       (ph == P_POST && post_left > 0));
    e.busy  = (ph == P_ARM || ph == P_WAIT || ph == P_POST);
    e.done  = (ph == P_DONE);
    e.trst  = (ph != P_WAIT);
    e.wr    = wr;
    e.taddr = m_taddr[AW-1:0];
    stq.push_back(e);
    if (wr) wq.push_back(m_addr[AW-1:0]);
    if (!rst_n) return;
    hit = s2 || force_trig;
    s2 = s1;
    s1 = trig;
    if (wr) m_addr = (m_addr + 1) % DEPTH;
    if (abort) begin
      ph = P_IDLE;
    end else begin
      case (ph)
        P_IDLE: if (start) begin
          room      = DEPTH - int'(pre_count);
          pre_left  = pre_count;
          post_left = (int'(post_count) < room) ? post_count : room;
          ph        = P_ARM;
        end
        P_ARM: begin
          if (pre_left == 0) ph = P_WAIT;
          else if (wr) begin
            pre_left--;
            if (pre_left == 0) ph = P_WAIT;
          end
        end
        P_WAIT: if (hit) begin
          m_taddr = m_addr;
          ph      = P_POST;
        end
        P_POST: begin
          if (post_left == 0) ph = P_DONE;
          else if (wr) begin
            post_left--;
            if (post_left == 0) ph = P_DONE;
          end
        end
        P_DONE: if (ack) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic step();
    if (arm_only) sample_en = (ph == P_ARM);
    model_eval();
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; ack = 1'b0; force_trig = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    for (int i = 0; i < budget && ph != target; i++) step();
    if (ph != target) chk(name, ph, target);
  endtask

  initial begin : monitor
    exp_t          e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (stq.size() > 0) begin
        e = stq.pop_front();
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("trig_reset", trig_reset, e.trst);
        chk("wr_en", wr_en, e.wr);
        chk("trig_addr", trig_addr, e.taddr);
      end
      if (wr_en) dut_writes++;
      if (wq.size() > 0) begin
        a = wq.pop_front();
        if (wr_en) chk("wr_addr", wr_addr, a);
      end
    end
  end

  initial begin : driver
    int w0;
    int unsigned a_force;
    @(posedge clk);
    #1;
    repeat (3) step();
    chk("reset_wr_addr", wr_addr, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Pre 4 / post 6, continuous samples, trigger 20 cycles into WAIT_TRIG.
    pre_count = 4; post_count = 6; sample_en = 1'b1; start = 1'b1;
    step();
    run_until(P_WAIT, 40, "a_reach_wait");
    repeat (20) step();
    trig = 1'b1;
    run_until(P_POST, 10, "a_trig_accept");
    w0 = dut_writes;
    run_until(P_DONE, 30, "a_reach_done");
    chk("a_post_writes", dut_writes - w0, 6);
    trig = 1'b0;
    repeat (5) step();
    chk("a_done_held", done, 1);
    ack = 1'b1;
    step();
    step();

    // Zero-length windows with Trig held high.
    pre_count = 0; post_count = 0; trig = 1'b1;
    repeat (3) step();
    start = 1'b1;
    step();
    w0 = -1;
    for (int i = 0; i < 6 && !done; i++) begin
      if (ph == P_DONE && w0 < 0) w0 = dut_writes;
      step();
    end
    chk("b_done_within_6", done, 1);
    trig = 1'b0;
    ack = 1'b1;
    step();
    step();

    // Abort + Start together in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    step();
    chk("abort_start_idle", busy, 0);

    // Walk WrAddr to 14, then pre 3 wraps through 14, 15, 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    arm_only = 1'b1;
    pre_count = 14; post_count = 0; start = 1'b1;
    step();
    run_until(P_WAIT, 40, "c_prep_wait");
    force_trig = 1'b1;
    step();
    run_until(P_DONE, 10, "c_prep_done");
    ack = 1'b1;
    step();
    pre_count = 3; post_count = 0; start = 1'b1;
    step();
    run_until(P_WAIT, 20, "c_reach_wait");
    force_trig = 1'b1;
    step();
    run_until(P_DONE, 10, "c_reach_done");
    chk("c_trig_addr", trig_addr, 1);
    ack = 1'b1;
    step();
    arm_only = 1'b0;

    // Post count saturates to DEPTH - PreCount.
    pre_count = 10; post_count = 20; sample_en = 1'b1; start = 1'b1;
    step();
    run_until(P_WAIT, 40, "d_reach_wait");
    force_trig = 1'b1;
    step();
    w0 = dut_writes;
    run_until(P_DONE, 40, "d_reach_done");
    chk("d_post_writes", dut_writes - w0, 6);
    ack = 1'b1;
    step();

    // ForceTrig with a coincident sample: that sample is pre-trigger.
    pre_count = 2; post_count = 3; start = 1'b1;
    step();
    run_until(P_WAIT, 20, "f_reach_wait");
    a_force = m_addr;
    force_trig = 1'b1;
    step();
    chk("f_trig_addr", trig_addr, int'((a_force + 1) % DEPTH));
    run_until(P_DONE, 20, "f_reach_done");
    ack = 1'b1;
    step();

    // Abort mid-POST, then reset mid-ARM.
    pre_count = 2; post_count = 10; start = 1'b1;
    step();
    run_until(P_WAIT, 20, "e_reach_wait");
    force_trig = 1'b1;
    step();
    repeat (3) step();
    abort = 1'b1;
    step();
    chk("e_abort_busy", busy, 0);
    chk("e_abort_trig_reset", trig_reset, 1);
    pre_count = 8; start = 1'b1;
    step();
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("e_reset_wr_addr", wr_addr, 0);
    chk("e_reset_busy", busy, 0);
    chk("e_reset_trig_reset", trig_reset, 1);
    rst_n = 1'b1;
    step();

    // Randomized traffic, including ignored Start/Ack and stray Abort.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      abort      = ($urandom_range(0, 99) == 0);
      ack        = ($urandom_range(0, 7) == 0);
      force_trig = ($urandom_range(0, 31) == 0);
      sample_en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) trig = ~trig;
      pre_count  = AW'($urandom_range(0, DEPTH - 1));
      post_count = (AW + 1)'($urandom_range(0, 2 * DEPTH - 1));
      step();
    end
    abort = 1'b1;
    step();
    step();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
